// File: rtl/var_tap_delay_line.sv
// var_tap_delay_line
// Selects one of two signed sample sources and delays the selected stream by
// a runtime-programmable number of sample strobes (1..MAX_DEPTH). The output
// is muted and flagged invalid until the chain holds enough samples captured
// since the last depth change or reset, so downstream mixing can crossfade.
module var_tap_delay_line #(
    parameter int WIDTH     = 16,
    parameter int MAX_DEPTH = 32,
    parameter int DEP_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic             a_clk,
    input  logic             sclr,
    input  logic             ce,
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [DEP_W-1:0] depth,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [DEP_W-1:0] depth_active
);

    localparam logic [DEP_W-1:0] MAX_D    = DEP_W'(MAX_DEPTH);
    localparam logic [DEP_W-1:0] ONE_D    = DEP_W'(1);
    localparam logic [DEP_W:0]   FILL_ONE = (DEP_W + 1)'(1);
    localparam logic [DEP_W:0]   FILL_SAT = (DEP_W + 1)'(MAX_DEPTH + 1);

    logic [WIDTH-1:0] stage_q [MAX_DEPTH];
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;
    logic [DEP_W-1:0] depth_act_q;
    logic [DEP_W-1:0] depth_act_d;
    logic [DEP_W:0]   fill_q;
    logic [DEP_W:0]   fill_d;
    logic [DEP_W-1:0] tap_idx;
    logic [WIDTH-1:0] tap_data;
    logic [WIDTH-1:0] src_data;
    logic             changed;

    // Clamp the requested depth into 1..MAX_DEPTH and derive the tap index.
    always_comb begin
        depth_act_d = depth;
        if (depth == '0) begin
            depth_act_d = ONE_D;
        end else if (depth > MAX_D) begin
            depth_act_d = MAX_D;
        end
        tap_idx = depth_act_d - ONE_D;
        changed = (depth_act_d != depth_act_q);
    end

    // MAX_DEPTH:1 output tap mux on the pre-edge stage contents.
    always_comb begin
        tap_data = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (tap_idx == DEP_W'(i)) begin
                tap_data = stage_q[i];
            end
        end
    end

    // Fill count restarts on a depth change and saturates so it never wraps;
    // the output is valid once the chain has been refilled past the tap.
    always_comb begin
        if (changed) begin
            fill_d = FILL_ONE;
        end else if (fill_q >= FILL_SAT) begin
            fill_d = FILL_SAT;
        end else begin
            fill_d = fill_q + FILL_ONE;
        end
        valid_d  = (fill_d > {1'b0, depth_act_d});
        data_d   = valid_d ? tap_data : '0;
        src_data = sel ? d0 : d1;
    end

    // Delay chain and registered outputs; everything advances only on strobes.
    always_ff @(posedge a_clk or posedge sclr) begin
        if (sclr) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            data_q      <= '0;
            valid_q     <= 1'b0;
            depth_act_q <= ONE_D;
            fill_q      <= '0;
        end else if (ce) begin
            stage_q[0] <= src_data;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            data_q      <= data_d;
            valid_q     <= valid_d;
            depth_act_q <= depth_act_d;
            fill_q      <= fill_d;
        end
    end

    assign q            = data_q;
    assign q_valid      = valid_q;
    assign depth_active = depth_act_q;

endmodule

// File: tb/tb_var_tap_delay_line.sv
// Testbench for var_tap_delay_line: directed scenarios plus a randomized run,
// all checked against a strobe-indexed history model.
module tb_var_tap_delay_line;

    localparam int W  = 16;
    localparam int MD = 32;
    localparam int DW = $clog2(MD + 1);
    localparam int HN = 8192;

    logic          a_clk = 1'b0;
    logic          sclr  = 1'b1;
    logic          ce    = 1'b0;
    logic          sel   = 1'b0;
    logic [W-1:0]  d0    = '0;
    logic [W-1:0]  d1    = '0;
    logic [DW-1:0] depth = '0;
    logic [W-1:0]  q;
    logic          q_valid;
    logic [DW-1:0] depth_active;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: samples indexed by strobe number since reset.
    logic [W-1:0]  hist [HN];
    int            m_k;
    int            m_c;
    int            m_da;
    logic [W-1:0]  exp_q;
    logic          exp_v;

    var_tap_delay_line #(.WIDTH(W), .MAX_DEPTH(MD)) dut (
        .a_clk(a_clk), .sclr(sclr), .ce(ce), .sel(sel), .d0(d0), .d1(d1),
        .depth(depth), .q(q), .q_valid(q_valid), .depth_active(depth_active)
    );

    always #5 a_clk = ~a_clk;

    task automatic model_reset();
        m_k = 0; m_c = 0; m_da = 1; exp_q = '0; exp_v = 1'b0;
    endtask

    task automatic model_strobe(input logic s, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [DW-1:0] dep);
        int dd;
        dd = (dep == 0) ? 1 : ((int'(dep) > MD) ? MD : int'(dep));
        if (dd != m_da) m_c = m_k;
        m_da = dd;
        if (m_k < HN) hist[m_k] = s ? a : b;
        if ((m_k - m_c) >= dd && (m_k - dd) < HN) begin
            exp_v = 1'b1; exp_q = hist[m_k - dd];
        end else begin
            exp_v = 1'b0; exp_q = '0;
        end
        m_k++;
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, return 1 time unit later for sampling.
    task automatic step(input logic ce_v, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [DW-1:0] dep);
        @(negedge a_clk);
        ce = ce_v; sel = s; d0 = a; d1 = b; depth = dep;
        @(posedge a_clk);
        if (ce_v) model_strobe(s, a, b, dep);
        #1;
    endtask

    task automatic do_reset();
        @(negedge a_clk);
        sclr = 1'b1; ce = 1'b0;
        @(negedge a_clk);
        sclr = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 10; s++) step(1'b1, 1'b1, W'(s + 7), '0, DW'(2));
        vectors++;
        if (q_valid !== 1'b1 || q !== W'(14)) begin
            miscompares++;
            $display("FAIL reset_prefill: q=%0d v=%0b exp q=14 v=1", q, q_valid);
        end
        @(negedge a_clk);
        #2 sclr = 1'b1;
        #1;
        vectors++;
        if (q !== '0 || q_valid !== 1'b0 || depth_active !== DW'(1)) begin
            miscompares++;
            $display("FAIL reset_async: q=%0d v=%0b da=%0d exp 0/0/1", q, q_valid, depth_active);
        end
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge a_clk);
            ce = c[0]; d0 = W'($urandom); d1 = W'($urandom); depth = DW'(3);
            @(posedge a_clk); #1;
            vectors++;
            if (q !== '0 || q_valid !== 1'b0 || depth_active !== DW'(1)) begin
                miscompares++;
                $display("FAIL reset_hold: q=%0d v=%0b da=%0d exp 0/0/1", q, q_valid, depth_active);
            end
        end
        @(negedge a_clk);
        sclr = 1'b0; ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, W'(99), W'(98), DW'(3));
            vectors++;
            if (q !== '0 || q_valid !== 1'b0 || depth_active !== DW'(1)) begin
                miscompares++;
                $display("FAIL reset_release_idle: q=%0d v=%0b da=%0d exp 0/0/1", q, q_valid, depth_active);
            end
        end
        for (int s = 0; s < 6; s++) begin
            step(1'b1, 1'b1, W'(s + 50), '0, DW'(1));
            vectors++;
            if (q !== exp_q || q_valid !== exp_v) begin
                miscompares++;
                $display("FAIL reset_restart: q=%0d v=%0b exp q=%0d v=%0b", q, q_valid, exp_q, exp_v);
            end
        end
    endtask

    task automatic test_basic_latency();
        do_reset();
        for (int s = 0; s < 16; s++) begin
            step(1'b1, 1'b1, W'(s + 1), W'(16'h5555), DW'(4));
            vectors++;
            if (q !== ((s < 4) ? W'(0) : W'(s - 3)) || q_valid !== (s >= 4)
                || depth_active !== DW'(4) || q !== exp_q || q_valid !== exp_v) begin
                miscompares++;
                $display("FAIL basic_latency s=%0d: q=%0d v=%0b da=%0d exp q=%0d v=%0b da=4",
                         s, q, q_valid, depth_active, (s < 4) ? 0 : s - 3, s >= 4);
            end
        end
    endtask

    task automatic test_sparse_ce();
        int n;
        n = 0;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            logic cv;
            cv = (c % 5 == 0);
            step(cv, 1'b1, W'(-100 * (n + 1)), W'(7), DW'(3));
            vectors++;
            if (q !== exp_q || q_valid !== exp_v || depth_active !== DW'(3)) begin
                miscompares++;
                $display("FAIL sparse_ce c=%0d: q=%0d v=%0b exp q=%0d v=%0b", c, q, q_valid, exp_q, exp_v);
            end
            if (cv && n == 3) begin
                vectors++;
                if (q !== W'(-100) || q_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sparse_first: q=%0h v=%0b exp q=%0h v=1", q, q_valid, W'(-100));
                end
            end
            if (cv) n++;
        end
    endtask

    task automatic test_depth_change();
        do_reset();
        for (int s = 0; s < 40; s++) begin
            logic [DW-1:0] dep;
            dep = (s < 20) ? DW'(4) : ((s < 32) ? DW'(8) : DW'(2));
            step(1'b1, 1'b1, W'(s + 1), '0, dep);
            vectors++;
            if (q !== exp_q || q_valid !== exp_v || depth_active !== dep) begin
                miscompares++;
                $display("FAIL depth_change s=%0d: q=%0d v=%0b da=%0d exp q=%0d v=%0b da=%0d",
                         s, q, q_valid, depth_active, exp_q, exp_v, dep);
            end
            if ((s >= 20 && s <= 27) || s == 32 || s == 33) begin
                vectors++;
                if (q_valid !== 1'b0 || q !== '0) begin
                    miscompares++;
                    $display("FAIL depth_mute s=%0d: q=%0d v=%0b exp q=0 v=0", s, q, q_valid);
                end
            end
            if (s == 28 || s == 34) begin
                vectors++;
                if (q_valid !== 1'b1 || q !== ((s == 28) ? W'(21) : W'(33))) begin
                    miscompares++;
                    $display("FAIL depth_resume s=%0d: q=%0d v=%0b exp q=%0d v=1",
                             s, q, q_valid, (s == 28) ? 21 : 33);
                end
            end
        end
    endtask

    task automatic test_clamp();
        do_reset();
        for (int s = 0; s < 50; s++) begin
            logic [DW-1:0] dep;
            logic [DW-1:0] eda;
            dep = (s < 6) ? DW'(0) : ((s < 10) ? DW'(1) : DW'(MD + 5));
            eda = (s < 10) ? DW'(1) : DW'(MD);
            step(1'b1, 1'b0, W'(16'h1234), W'(s * 3 + 1), dep);
            vectors++;
            if (q !== exp_q || q_valid !== exp_v || depth_active !== eda) begin
                miscompares++;
                $display("FAIL clamp s=%0d: q=%0d v=%0b da=%0d exp q=%0d v=%0b da=%0d",
                         s, q, q_valid, depth_active, exp_q, exp_v, eda);
            end
            if ((s >= 1 && s < 10) || s >= 42) begin
                vectors++;
                if (q_valid !== 1'b1 || q !== ((s < 10) ? W'((s - 1) * 3 + 1) : W'((s - MD) * 3 + 1))) begin
                    miscompares++;
                    $display("FAIL clamp_delay s=%0d: q=%0d v=%0b", s, q, q_valid);
                end
            end else if (s >= 10 && s < 42) begin
                vectors++;
                if (q_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clamp_mute s=%0d: v=%0b exp v=0", s, q_valid);
                end
            end
        end
    endtask

    task automatic test_source_select();
        do_reset();
        for (int s = 0; s < 20; s++) begin
            step(1'b1, (s % 2 == 0), W'(1000), W'(-1000), DW'(5));
            vectors++;
            if (q !== exp_q || q_valid !== exp_v ||
                q !== ((s < 5) ? W'(0) : (((s - 5) % 2 == 0) ? W'(1000) : W'(-1000)))) begin
                miscompares++;
                $display("FAIL source_select s=%0d: q=%0d v=%0b exp q=%0d v=%0b", s, q, q_valid, exp_q, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] dep;
        dep = DW'(7);
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end
            if ($urandom_range(99) < 4) dep = DW'($urandom_range(40));
            step($urandom_range(99) < 70, 1'($urandom), W'($urandom), W'($urandom), dep);
            vectors++;
            if (q !== exp_q || q_valid !== exp_v || depth_active !== DW'(m_da)) begin
                miscompares++;
                $display("FAIL random c=%0d: q=%0h v=%0b da=%0d exp q=%0h v=%0b da=%0d",
                         c, q, q_valid, depth_active, exp_q, exp_v, m_da);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_latency();
        test_sparse_ce();
        test_depth_change();
        test_clamp();
        test_source_select();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
